// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply engine and its host-side stream source.
package mm_pkg;

  localparam int unsigned MAX_DIM = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 20;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [RES_W-1:0]  res_t;

  typedef enum logic [2:0] {
    StIdle,
    StSendM1,
    StSendM2,
    StWait,
    StDone
  } state_e;

  function automatic logic dim_ok(input logic [2:0] d);
    return (d != 3'd0) && (d <= 3'(MAX_DIM));
  endfunction

endpackage

// File: rtl/mm_result_buf.sv
// Result buffer: one synchronous write port, one asynchronous read port, no reset.
module mm_result_buf
  import mm_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = RES_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mm_stream_tx.sv
// Streams two host-written operand matrices to the engine and collects its results.
// Optional watchdog in WAIT (adds a timeout output) when MM_TX_TIMEOUT_EN is defined.
module mm_stream_tx
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [1:0]        cfg_row,
  input  logic [1:0]        cfg_col,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [2:0]        m1_rows,
  input  logic [2:0]        m1_cols,
  input  logic [2:0]        m2_rows,
  input  logic [2:0]        m2_cols,
  input  logic              start,
  output logic [DATA_W-1:0] in_data,
  output logic              col_end,
  output logic              row_end,
  input  logic              busy,
  input  logic              valid,
  input  logic              is_legal,
  input  logic [RES_W-1:0]  out_data,
  input  logic              change_row,
  output logic              done,
  output logic              result_legal,
  output logic              err_cfg,
  output logic [4:0]        res_count,
  output logic [2:0]        rows_seen,
`ifdef MM_TX_TIMEOUT_EN
  output logic              timeout,
`endif
  input  logic [3:0]        rd_addr,
  output logic [RES_W-1:0]  rd_data
);

  state_e state_q;

  elem_t op_q [2][MAX_DIM][MAX_DIM];

  logic [1:0]        row_q, col_q;
  logic [2:0]        r1_q, c1_q, r2_q, c2_q;
  logic [DATA_W-1:0] in_data_q;
  logic              col_end_q, row_end_q;
  logic              done_q, result_legal_q, err_cfg_q;
  logic [4:0]        res_count_q;
  logic [2:0]        rows_seen_q;
`ifdef MM_TX_TIMEOUT_EN
  logic [7:0]        wd_q;
  logic              timeout_q;
`endif

  // Status only; the stream never stalls on it.
  logic unused_busy;
  assign unused_busy = busy;

  logic       sel_m2;
  logic [2:0] cur_rows, cur_cols;
  elem_t      cur_elem;
  logic       last_col, last_row;
  logic [4:0] target;
  logic       start_ok;
  logic       buf_we;

  always_comb begin
    sel_m2   = (state_q == StSendM2);
    cur_rows = sel_m2 ? r2_q : r1_q;
    cur_cols = sel_m2 ? c2_q : c1_q;
    cur_elem = op_q[sel_m2][row_q][col_q];
    last_col = ((3'(col_q) + 3'd1) == cur_cols);
    last_row = ((3'(row_q) + 3'd1) == cur_rows);
    target   = {2'b00, r1_q} * {2'b00, c2_q};
    start_ok = dim_ok(m1_rows) && dim_ok(m1_cols) && dim_ok(m2_rows) && dim_ok(m2_cols);
    buf_we   = (state_q == StWait) && valid && is_legal;
  end

  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && cfg_we) begin
      op_q[cfg_sel][cfg_row][cfg_col] <= elem_t'(cfg_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      row_q          <= 2'd0;
      col_q          <= 2'd0;
      r1_q           <= 3'd0;
      c1_q           <= 3'd0;
      r2_q           <= 3'd0;
      c2_q           <= 3'd0;
      in_data_q      <= '0;
      col_end_q      <= 1'b0;
      row_end_q      <= 1'b0;
      done_q         <= 1'b0;
      result_legal_q <= 1'b0;
      err_cfg_q      <= 1'b0;
      res_count_q    <= 5'd0;
      rows_seen_q    <= 3'd0;
`ifdef MM_TX_TIMEOUT_EN
      wd_q           <= 8'd0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      err_cfg_q <= 1'b0;
      in_data_q <= '0;
      col_end_q <= 1'b0;
      row_end_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (start_ok) begin
              r1_q           <= m1_rows;
              c1_q           <= m1_cols;
              r2_q           <= m2_rows;
              c2_q           <= m2_cols;
              row_q          <= 2'd0;
              col_q          <= 2'd0;
              res_count_q    <= 5'd0;
              rows_seen_q    <= 3'd0;
              result_legal_q <= 1'b0;
`ifdef MM_TX_TIMEOUT_EN
              wd_q           <= 8'd0;
              timeout_q      <= 1'b0;
`endif
              state_q        <= StSendM1;
            end else begin
              err_cfg_q <= 1'b1;
            end
          end
        end
        StSendM1, StSendM2: begin
          in_data_q <= cur_elem;
          col_end_q <= last_col && !last_row;
          row_end_q <= last_col && last_row;
          if (last_col) begin
            col_q <= 2'd0;
            if (last_row) begin
              row_q   <= 2'd0;
              state_q <= sel_m2 ? StWait : StSendM2;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end else begin
            col_q <= col_q + 2'd1;
          end
        end
        StWait: begin
          if (change_row && (rows_seen_q != 3'd7)) begin
            rows_seen_q <= rows_seen_q + 3'd1;
          end
          if (valid) begin
            if (is_legal) begin
              res_count_q    <= res_count_q + 5'd1;
              result_legal_q <= 1'b1;
              if ((res_count_q + 5'd1) == target) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end
            end else begin
              result_legal_q <= 1'b0;
              done_q         <= 1'b1;
              state_q        <= StDone;
            end
          end
`ifdef MM_TX_TIMEOUT_EN
          if (valid) begin
            wd_q <= 8'd0;
          end else if (wd_q == 8'hFF) begin
            timeout_q      <= 1'b1;
            result_legal_q <= 1'b0;
            done_q         <= 1'b1;
            state_q        <= StDone;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
`endif
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  mm_result_buf #(
    .Depth(16),
    .Width(RES_W)
  ) u_result_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(res_count_q[3:0]),
    .wdata(out_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign in_data      = in_data_q;
  assign col_end      = col_end_q;
  assign row_end      = row_end_q;
  assign done         = done_q;
  assign result_legal = result_legal_q;
  assign err_cfg      = err_cfg_q;
  assign res_count    = res_count_q;
  assign rows_seen    = rows_seen_q;
`ifdef MM_TX_TIMEOUT_EN
  assign timeout      = timeout_q;
`endif

endmodule

// File: tb/tb_mm_stream_tx.sv
// Directed, table-driven bench for mm_stream_tx; the bench plays the engine's output side.
module tb_mm_stream_tx;
  import mm_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we, cfg_sel;
  logic [1:0]        cfg_row, cfg_col;
  logic [DATA_W-1:0] cfg_data;
  logic [2:0]        m1_rows, m1_cols, m2_rows, m2_cols;
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              col_end, row_end;
  logic              busy, valid, is_legal;
  logic [RES_W-1:0]  out_data;
  logic              change_row;
  logic              done, result_legal, err_cfg;
  logic [4:0]        res_count;
  logic [2:0]        rows_seen;
  logic [3:0]        rd_addr;
  logic [RES_W-1:0]  rd_data;
`ifdef MM_TX_TIMEOUT_EN
  logic              timeout;
`endif

  always #5 clk = ~clk;

  mm_stream_tx dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_row     (cfg_row),
    .cfg_col     (cfg_col),
    .cfg_data    (cfg_data),
    .m1_rows     (m1_rows),
    .m1_cols     (m1_cols),
    .m2_rows     (m2_rows),
    .m2_cols     (m2_cols),
    .start       (start),
    .in_data     (in_data),
    .col_end     (col_end),
    .row_end     (row_end),
    .busy        (busy),
    .valid       (valid),
    .is_legal    (is_legal),
    .out_data    (out_data),
    .change_row  (change_row),
    .done        (done),
    .result_legal(result_legal),
    .err_cfg     (err_cfg),
    .res_count   (res_count),
    .rows_seen   (rows_seen),
`ifdef MM_TX_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  typedef struct {
    logic [2:0]              r1, c1, r2, c2;
    logic [15:0][7:0]        m1, m2;      // index row*4+col
    int                      len;
    logic [31:0][7:0]        stream;
    logic [31:0]             ce, re;      // expected col_end/row_end per stream cycle
    int                      nres;
    logic                    legal_resp;
    logic [15:0][RES_W-1:0]  res;
    logic [4:0]              exp_count;
    logic                    exp_legal;
    logic [2:0]              exp_rows;
  } vec_t;

  vec_t tv [4];

  int s0 [8]  = '{1, 2, 3, 4, 1, 0, 0, 1};
  int s3 [10] = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_matrix(input logic sel, input logic [15:0][7:0] m);
    for (int k = 0; k < 16; k++) begin
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_row  = 2'(k / 4);
      cfg_col  = 2'(k % 4);
      cfg_data = m[k];
      tick();
    end
    cfg_we = 1'b0;
  endtask

  task automatic set_dims(input logic [2:0] a, b, c, d);
    m1_rows = a;
    m1_cols = b;
    m2_rows = c;
    m2_cols = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0][7:0] mseq;
    int c2i;

    rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_row = '0; cfg_col = '0; cfg_data = '0;
    start = 1'b0; busy = 1'b0; valid = 1'b0; is_legal = 1'b0; out_data = '0;
    change_row = 1'b0; rd_addr = '0;
    set_dims(3'd0, 3'd0, 3'd0, 3'd0);
    tick(); tick();
    rst = 1'b0;

    check("reset in_data", 32'(in_data), 0);
    check("reset col_end", 32'(col_end), 0);
    check("reset row_end", 32'(row_end), 0);
    check("reset done", 32'(done), 0);
    check("reset result_legal", 32'(result_legal), 0);
    check("reset err_cfg", 32'(err_cfg), 0);
    check("reset res_count", 32'(res_count), 0);
    check("reset rows_seen", 32'(rows_seen), 0);

    for (int i = 0; i < 4; i++) begin
      tv[i].m1 = '0; tv[i].m2 = '0; tv[i].stream = '0; tv[i].res = '0;
      tv[i].ce = '0; tv[i].re = '0;
    end
    // 2x2 [[1,2],[3,4]] x identity
    tv[0].r1 = 3'd2; tv[0].c1 = 3'd2; tv[0].r2 = 3'd2; tv[0].c2 = 3'd2;
    tv[0].m1[0] = 8'd1; tv[0].m1[1] = 8'd2; tv[0].m1[4] = 8'd3; tv[0].m1[5] = 8'd4;
    tv[0].m2[0] = 8'd1; tv[0].m2[5] = 8'd1;
    tv[0].len = 8;
    for (int k = 0; k < 8; k++) tv[0].stream[k] = 8'(s0[k]);
    tv[0].ce = 32'h0000_0022; tv[0].re = 32'h0000_0088;
    tv[0].nres = 4; tv[0].legal_resp = 1'b1;
    for (int k = 0; k < 4; k++) tv[0].res[k] = RES_W'(k + 1);
    tv[0].exp_count = 5'd4; tv[0].exp_legal = 1'b1; tv[0].exp_rows = 3'd2;
    // 1x1 [-128] x [-128]
    tv[1].r1 = 3'd1; tv[1].c1 = 3'd1; tv[1].r2 = 3'd1; tv[1].c2 = 3'd1;
    tv[1].m1[0] = 8'h80; tv[1].m2[0] = 8'h80;
    tv[1].len = 2; tv[1].stream[0] = 8'h80; tv[1].stream[1] = 8'h80;
    tv[1].ce = 32'h0; tv[1].re = 32'h3;
    tv[1].nres = 1; tv[1].legal_resp = 1'b1; tv[1].res[0] = 20'd16384;
    tv[1].exp_count = 5'd1; tv[1].exp_legal = 1'b1; tv[1].exp_rows = 3'd1;
    // 4x4 all 127 squared
    tv[2].r1 = 3'd4; tv[2].c1 = 3'd4; tv[2].r2 = 3'd4; tv[2].c2 = 3'd4;
    for (int k = 0; k < 16; k++) begin
      tv[2].m1[k] = 8'd127; tv[2].m2[k] = 8'd127; tv[2].res[k] = 20'd64516;
    end
    tv[2].len = 32;
    for (int k = 0; k < 32; k++) tv[2].stream[k] = 8'd127;
    tv[2].ce = 32'h0888_0888; tv[2].re = 32'h8000_8000;
    tv[2].nres = 16; tv[2].legal_resp = 1'b1;
    tv[2].exp_count = 5'd16; tv[2].exp_legal = 1'b1; tv[2].exp_rows = 3'd4;
    // 2x3 x 2x2, engine flags illegal
    tv[3].r1 = 3'd2; tv[3].c1 = 3'd3; tv[3].r2 = 3'd2; tv[3].c2 = 3'd2;
    tv[3].m1[0] = 8'd1; tv[3].m1[1] = 8'd2; tv[3].m1[2] = 8'd3;
    tv[3].m1[4] = 8'd4; tv[3].m1[5] = 8'd5; tv[3].m1[6] = 8'd6;
    tv[3].m2[0] = 8'd1; tv[3].m2[1] = 8'd2; tv[3].m2[4] = 8'd3; tv[3].m2[5] = 8'd4;
    tv[3].len = 10;
    for (int k = 0; k < 10; k++) tv[3].stream[k] = 8'(s3[k]);
    tv[3].ce = 32'h0000_0084; tv[3].re = 32'h0000_0220;
    tv[3].nres = 1; tv[3].legal_resp = 1'b0; tv[3].res[0] = 20'h12345;
    tv[3].exp_count = 5'd0; tv[3].exp_legal = 1'b0; tv[3].exp_rows = 3'd0;

    for (int i = 0; i < 4; i++) begin
      load_matrix(1'b0, tv[i].m1);
      load_matrix(1'b1, tv[i].m2);
      set_dims(tv[i].r1, tv[i].c1, tv[i].r2, tv[i].c2);
      busy  = (i == 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("first cycle still quiet", 32'(in_data), 0);
      for (int s = 0; s < tv[i].len; s++) begin
        if (i == 0 && s == 1) begin
          start = 1'b1;
          set_dims(3'd1, 3'd1, 3'd1, 3'd1);
        end
        tick();
        start = 1'b0;
        set_dims(tv[i].r1, tv[i].c1, tv[i].r2, tv[i].c2);
        check($sformatf("case%0d in_data[%0d]", i, s), 32'(in_data), 32'(tv[i].stream[s]));
        check($sformatf("case%0d col_end[%0d]", i, s), 32'(col_end), 32'(tv[i].ce[s]));
        check($sformatf("case%0d row_end[%0d]", i, s), 32'(row_end), 32'(tv[i].re[s]));
      end
      busy = 1'b0;
      tick();
      check($sformatf("case%0d stream tail", i), {in_data, col_end, row_end}, 0);
      tick();
      c2i = int'(tv[i].c2);
      for (int k = 0; k < tv[i].nres; k++) begin
        valid      = 1'b1;
        is_legal   = tv[i].legal_resp;
        out_data   = tv[i].res[k];
        change_row = tv[i].legal_resp && ((k % c2i) == c2i - 1);
        tick();
        valid = 1'b0; is_legal = 1'b0; change_row = 1'b0;
        if (k < tv[i].nres - 1) check($sformatf("case%0d early done", i), 32'(done), 0);
      end
      check($sformatf("case%0d done pulse", i), 32'(done), 1);
      check($sformatf("case%0d res_count", i), 32'(res_count), 32'(tv[i].exp_count));
      check($sformatf("case%0d result_legal", i), 32'(result_legal), 32'(tv[i].exp_legal));
      check($sformatf("case%0d rows_seen", i), 32'(rows_seen), 32'(tv[i].exp_rows));
      tick();
      check($sformatf("case%0d done one cycle", i), 32'(done), 0);
      check($sformatf("case%0d res_count held", i), 32'(res_count), 32'(tv[i].exp_count));
      for (int k = 0; k < int'(tv[i].exp_count); k++) begin
        rd_addr = 4'(k);
        #1;
        check($sformatf("case%0d buffer[%0d]", i, k), 32'(rd_data), 32'(tv[i].res[k]));
      end
      tick();
    end

    // Rejected start: a zero dimension, then an oversize dimension
    set_dims(3'd2, 3'd0, 3'd2, 3'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cfg zero dim", 32'(err_cfg), 1);
    tick();
    check("err_cfg one cycle", 32'(err_cfg), 0);
    check("no stream after reject", {in_data, col_end, row_end}, 0);
    tick();
    check("still no stream", {in_data, col_end, row_end}, 0);
    set_dims(3'd2, 3'd2, 3'd5, 3'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_cfg dim 5", 32'(err_cfg), 1);
    tick();
    check("no stream after dim 5", 32'(in_data), 0);

    // Reset in the middle of a 4x4 M1, then a fresh start
    for (int k = 0; k < 16; k++) mseq[k] = 8'(k + 1);
    load_matrix(1'b0, mseq);
    set_dims(3'd4, 3'd4, 3'd4, 3'd4);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("third element before reset", 32'(in_data), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-stream reset outputs", {in_data, col_end, row_end, done, err_cfg}, 0);
    check("mid-stream reset counts", {res_count, rows_seen, result_legal}, 0);
    tick();
    check("idle after reset", {in_data, row_end}, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("restart in_data[%0d]", s), 32'(in_data), 32'(s + 1));
      check($sformatf("restart col_end[%0d]", s), 32'(col_end), (s == 3) ? 1 : 0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
